// File: rtl/des_tdes_control_unit.sv
// des_tdes_control_unit
// Sequencer for an iterative DES / 3DES (EDE) datapath. It runs one IP, then
// ROUNDS Feistel rounds per pass (1 or 3 passes back to back), then one FP.
// The inner FP/IP pairs between 3DES passes cancel, so the passes are fused
// and no permutation is issued between them.
//
// Handshakes: a request is accepted on a cycle where start_valid && start_ready,
// and start_ready is high only in IDLE. A result is handed over on a cycle
// where out_valid && out_ready. out_valid stays high and the result is held
// until that cycle.
//
// pass_idx and round_idx hold their last values through FINAL. They read 0 in
// IDLE, DONE and ERROR. key_sel and key_dir are only meaningful while busy and
// read 0 otherwise.

module des_tdes_control_unit #(
    parameter int ROUNDS = 16,
    parameter int CNT_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic             mode_3des,
    input  logic             decrypt,
    input  logic             key_ready,
    input  logic             abort,
    input  logic             out_ready,
    output logic             out_valid,
    output logic             error,
    output logic             busy,
    output logic [1:0]       pass_idx,
    output logic [CNT_W-1:0] round_idx,
    output logic [1:0]       key_sel,
    output logic             key_dir,
    output logic             en_ip,
    output logic             en_round,
    output logic             en_fp,
    output logic             sel_input,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ROUND = 3'd2,
        S_FINAL = 3'd3,
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(ROUNDS - 1);

    state_t           st;
    logic [1:0]       pass_q;
    logic [CNT_W-1:0] round_q;
    logic             mode_q;
    logic             dec_q;
    logic [1:0]       last_pass;

    // The final pass index depends on the mode captured at accept.
    assign last_pass = mode_q ? 2'd2 : 2'd0;

    // Control FSM with its pass/round counters and the mode captured at accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= S_IDLE;
            pass_q  <= 2'd0;
            round_q <= '0;
            mode_q  <= 1'b0;
            dec_q   <= 1'b0;
        end else begin
            case (st)
                S_IDLE: begin
                    pass_q  <= 2'd0;
                    round_q <= '0;
                    if (start_valid) begin
                        mode_q <= mode_3des;
                        dec_q  <= decrypt;
                        st     <= key_ready ? S_LOAD : S_ERROR;
                    end
                end
                S_LOAD: begin
                    st <= abort ? S_IDLE : S_ROUND;
                end
                S_ROUND: begin
                    if (abort) begin
                        st      <= S_IDLE;
                        pass_q  <= 2'd0;
                        round_q <= '0;
                    end else if (round_q == LAST_ROUND) begin
                        if (pass_q == last_pass) begin
                            st <= S_FINAL;
                        end else begin
                            round_q <= '0;
                            pass_q  <= pass_q + 2'd1;
                        end
                    end else begin
                        round_q <= round_q + 1'b1;
                    end
                end
                S_FINAL: begin
                    st      <= abort ? S_IDLE : S_DONE;
                    pass_q  <= 2'd0;
                    round_q <= '0;
                end
                S_DONE: begin
                    if (out_ready) begin
                        st <= S_IDLE;
                    end
                end
                S_ERROR: begin
                    if (!start_valid) begin
                        st <= S_IDLE;
                    end
                end
                default: begin
                    st      <= S_IDLE;
                    pass_q  <= 2'd0;
                    round_q <= '0;
                end
            endcase
        end
    end

    // Status and enables are plain decodes of the registered state.
    assign state       = st;
    assign start_ready = (st == S_IDLE);
    assign out_valid   = (st == S_DONE);
    assign error       = (st == S_ERROR);
    assign busy        = (st == S_LOAD) || (st == S_ROUND) || (st == S_FINAL);
    assign en_ip       = (st == S_LOAD);
    assign sel_input   = (st == S_LOAD);
    assign en_round    = (st == S_ROUND);
    assign en_fp       = (st == S_FINAL);
    assign pass_idx    = pass_q;
    assign round_idx   = round_q;

    // EDE key order: decrypt walks K3,K2,K1. The middle 3DES pass runs in the
    // opposite direction to the outer two.
    assign key_sel = !busy   ? 2'd0 :
                     !mode_q ? 2'd0 :
                     dec_q   ? (2'd2 - pass_q) : pass_q;
    assign key_dir = busy && (dec_q ^ (mode_q && (pass_q == 2'd1)));

endmodule

// File: tb/tb_des_tdes_control_unit.sv
// tb_des_tdes_control_unit
// Testbench for des_tdes_control_unit. Instance dut uses ROUNDS=16. Instance
// dut8 uses ROUNDS=8 and is used for the mid-round reset scenario.
// Expected outputs come from a cycle-indexed model of an operation: the cycle
// number counted from accept decides the phase, pass and round arithmetically.

module tb_des_tdes_control_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ROUNDS=16 instance
    logic       rst, start_valid, mode_3des, decrypt, key_ready, abort, out_ready;
    logic       start_ready, out_valid, error, busy, key_dir, en_ip, en_round, en_fp, sel_input;
    logic [1:0] pass_idx, key_sel;
    logic [4:0] round_idx;
    logic [2:0] state;

    // ROUNDS=8 instance
    logic       rst_b, start_valid_b;
    logic       start_ready_b, out_valid_b, error_b, busy_b, key_dir_b, en_ip_b, en_round_b, en_fp_b, sel_input_b;
    logic [1:0] pass_idx_b, key_sel_b;
    logic [4:0] round_idx_b;
    logic [2:0] state_b;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    des_tdes_control_unit #(.ROUNDS(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
        .mode_3des(mode_3des), .decrypt(decrypt), .key_ready(key_ready), .abort(abort),
        .out_ready(out_ready), .out_valid(out_valid), .error(error), .busy(busy),
        .pass_idx(pass_idx), .round_idx(round_idx), .key_sel(key_sel), .key_dir(key_dir),
        .en_ip(en_ip), .en_round(en_round), .en_fp(en_fp), .sel_input(sel_input), .state(state)
    );

    des_tdes_control_unit #(.ROUNDS(8), .CNT_W(5)) dut8 (
        .clk(clk), .rst(rst_b), .start_valid(start_valid_b), .start_ready(start_ready_b),
        .mode_3des(1'b0), .decrypt(1'b0), .key_ready(1'b1), .abort(1'b0),
        .out_ready(1'b1), .out_valid(out_valid_b), .error(error_b), .busy(busy_b),
        .pass_idx(pass_idx_b), .round_idx(round_idx_b), .key_sel(key_sel_b), .key_dir(key_dir_b),
        .en_ip(en_ip_b), .en_round(en_round_b), .en_fp(en_fp_b), .sel_input(sel_input_b), .state(state_b)
    );

    logic [20:0] obs, obs_b;
    assign obs   = {state, start_ready, out_valid, error, busy, pass_idx, round_idx,
                    key_sel, key_dir, en_ip, en_round, en_fp, sel_input};
    assign obs_b = {state_b, start_ready_b, out_valid_b, error_b, busy_b, pass_idx_b, round_idx_b,
                    key_sel_b, key_dir_b, en_ip_b, en_round_b, en_fp_b, sel_input_b};

    // ---------------- reference model ----------------
    function automatic logic [20:0] vec(int st, int p, int r, int ks, int kd);
        return {3'(st), st == 0, st == 4, st == 5, (st >= 1 && st <= 3), 2'(p), 5'(r),
                2'(ks), 1'(kd), st == 1, st == 2, st == 3, st == 1};
    endfunction

    function automatic int key_of(int p, bit m, bit d);
        if (!m) return 0;
        return d ? 2 - p : p;
    endfunction

    function automatic int dir_of(int p, bit m, bit d);
        return (d ^ (m && p == 1)) ? 1 : 0;
    endfunction

    // Expected outputs k cycles after the accept cycle, for a run that is not aborted
    // and whose DONE phase is still waiting.
    function automatic logic [20:0] model_at(int k, int nr, bit m, bit d);
        int np;
        int j;
        np = m ? 3 : 1;
        if (k == 1) return vec(1, 0, 0, key_of(0, m, d), dir_of(0, m, d));
        if (k <= 1 + nr * np) begin
            j = k - 2;
            return vec(2, j / nr, j % nr, key_of(j / nr, m, d), dir_of(j / nr, m, d));
        end
        if (k == 2 + nr * np) return vec(3, np - 1, nr - 1, key_of(np - 1, m, d), dir_of(np - 1, m, d));
        return vec(4, 0, 0, 0, 0);
    endfunction

    // ---------------- driver ----------------
    // One operation on dut. bp = extra DONE cycles with out_ready=0. abort_k > 0 pulses
    // abort k cycles after accept.
    task automatic run_op(input bit m, input bit d, input int bp, input int abort_k,
                          output int ov_k, output int rcnt, output int fp_cnt,
                          output logic [5:0] ks_seq, output logic [2:0] kd_seq);
        int          done_k;
        int          last_k;
        logic [20:0] exp_v;
        done_k = 3 + 16 * (m ? 3 : 1);
        last_k = (abort_k > 0) ? abort_k + 2 : done_k + bp + 1;
        ov_k = -1; rcnt = 0; fp_cnt = 0; ks_seq = '0; kd_seq = '0;
        @(negedge clk);
        assert_cnt++;
        if (obs !== vec(0, 0, 0, 0, 0)) begin
            fail_cnt++;
            $display("FAIL run_op_idle: got %h expected %h", obs, vec(0, 0, 0, 0, 0));
        end
        start_valid = 1'b1; mode_3des = m; decrypt = d; key_ready = 1'b1;
        abort = 1'($urandom_range(0, 1)); out_ready = 1'($urandom_range(0, 1));
        for (int k = 1; k <= last_k; k++) begin
            @(negedge clk);
            if (abort_k > 0 && k > abort_k) exp_v = vec(0, 0, 0, 0, 0);
            else if (abort_k <= 0 && k > done_k + bp) exp_v = vec(0, 0, 0, 0, 0);
            else exp_v = model_at(k, 16, m, d);
            assert_cnt++;
            if (obs !== exp_v) begin
                fail_cnt++;
                $display("FAIL run_op_k%0d (m=%0d d=%0d): got %h expected %h", k, m, d, obs, exp_v);
            end
            if (out_valid && ov_k < 0) ov_k = k;
            if (en_fp) fp_cnt++;
            if (en_round) begin
                rcnt++;
                if (round_idx == 5'd0 && pass_idx <= 2'd2) begin
                    ks_seq[pass_idx*2 +: 2] = key_sel;
                    kd_seq[pass_idx]        = key_dir;
                end
            end
            start_valid = 1'b0;
            mode_3des = 1'($urandom_range(0, 1));
            decrypt   = 1'($urandom_range(0, 1));
            key_ready = 1'($urandom_range(0, 1));
            if (k < done_k) begin
                abort     = (k == abort_k);
                out_ready = 1'($urandom_range(0, 1));
            end else begin
                abort     = 1'($urandom_range(0, 1));
                out_ready = (k >= done_k + bp);
            end
        end
        abort = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst = 1'b1; rst_b = 1'b1;
        start_valid = 1'b1; start_valid_b = 1'b1;
        mode_3des = 1'b1; decrypt = 1'b1; key_ready = 1'b1; abort = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            assert_cnt++;
            if (obs !== vec(0, 0, 0, 0, 0)) begin
                fail_cnt++;
                $display("FAIL reset_during: got %h expected %h", obs, vec(0, 0, 0, 0, 0));
            end
        end
        rst = 1'b0; rst_b = 1'b0; start_valid = 1'b0; start_valid_b = 1'b0; abort = 1'b0;
        @(negedge clk);
        assert_cnt++;
        if (obs !== vec(0, 0, 0, 0, 0) || obs_b !== vec(0, 0, 0, 0, 0)) begin
            fail_cnt++;
            $display("FAIL reset_after: got %h / %h expected %h", obs, obs_b, vec(0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_des_encrypt;
        int ov_k, rcnt, fpc;
        logic [5:0] ks;
        logic [2:0] kd;
        run_op(1'b0, 1'b0, 0, -1, ov_k, rcnt, fpc, ks, kd);
        assert_cnt++;
        if (ov_k !== 19 || rcnt !== 16 || fpc !== 1 || ks[1:0] !== 2'd0 || kd[0] !== 1'b0) begin
            fail_cnt++;
            $display("FAIL des_encrypt: ov=%0d rounds=%0d fp=%0d ks=%0d kd=%0d expected 19/16/1/0/0",
                     ov_k, rcnt, fpc, ks[1:0], kd[0]);
        end
    endtask

    task automatic test_3des_decrypt;
        int ov_k, rcnt, fpc;
        logic [5:0] ks;
        logic [2:0] kd;
        run_op(1'b1, 1'b1, 0, -1, ov_k, rcnt, fpc, ks, kd);
        assert_cnt++;
        if (ov_k !== 51 || rcnt !== 48 || fpc !== 1 || ks !== 6'b00_01_10 || kd !== 3'b101) begin
            fail_cnt++;
            $display("FAIL 3des_decrypt: ov=%0d rounds=%0d fp=%0d ks=%b kd=%b expected 51/48/1/000110/101",
                     ov_k, rcnt, fpc, ks, kd);
        end
    endtask

    task automatic test_key_missing;
        int hold;
        hold = $urandom_range(1, 3);
        @(negedge clk);
        start_valid = 1'b1; key_ready = 1'b0; mode_3des = 1'b1; decrypt = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            assert_cnt++;
            if (obs !== vec(5, 0, 0, 0, 0)) begin
                fail_cnt++;
                $display("FAIL key_missing_err%0d: got %h expected %h", i, obs, vec(5, 0, 0, 0, 0));
            end
            key_ready = 1'b1;
        end
        start_valid = 1'b0;
        @(negedge clk);
        assert_cnt++;
        if (obs !== vec(0, 0, 0, 0, 0)) begin
            fail_cnt++;
            $display("FAIL key_missing_idle: got %h expected %h", obs, vec(0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_backpressure;
        int ov_k, rcnt, fpc;
        logic [5:0] ks;
        logic [2:0] kd;
        run_op(1'b0, 1'b1, 5, -1, ov_k, rcnt, fpc, ks, kd);
        assert_cnt++;
        if (ov_k !== 19 || kd[0] !== 1'b1) begin
            fail_cnt++;
            $display("FAIL backpressure: ov=%0d kd=%0d expected 19/1", ov_k, kd[0]);
        end
    endtask

    task automatic test_abort;
        int ov_k, rcnt, fpc;
        logic [5:0] ks;
        logic [2:0] kd;
        // pass 1, round 7 is 2 + 16 + 7 cycles after accept
        run_op(1'b1, 1'b0, 0, 25, ov_k, rcnt, fpc, ks, kd);
        assert_cnt++;
        if (ov_k !== -1 || fpc !== 0 || rcnt !== 24) begin
            fail_cnt++;
            $display("FAIL abort: ov=%0d fp=%0d rounds=%0d expected -1/0/24", ov_k, fpc, rcnt);
        end
        run_op(1'b0, 1'b0, 0, -1, ov_k, rcnt, fpc, ks, kd);
        assert_cnt++;
        if (ov_k !== 19 || rcnt !== 16) begin
            fail_cnt++;
            $display("FAIL abort_next_req: ov=%0d rounds=%0d expected 19/16", ov_k, rcnt);
        end
    endtask

    task automatic test_random;
        int ov_k, rcnt, fpc, bp, ak, np;
        bit m, d;
        logic [5:0] ks;
        logic [2:0] kd;
        for (int i = 0; i < 8; i++) begin
            m  = 1'($urandom_range(0, 1));
            d  = 1'($urandom_range(0, 1));
            np = m ? 3 : 1;
            bp = $urandom_range(0, 3);
            ak = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2 + 16 * np) : -1;
            run_op(m, d, bp, ak, ov_k, rcnt, fpc, ks, kd);
            assert_cnt++;
            if (ak < 0 && ov_k !== 3 + 16 * np) begin
                fail_cnt++;
                $display("FAIL random_latency%0d: ov=%0d expected %0d", i, ov_k, 3 + 16 * np);
            end else if (ak > 0 && ov_k !== -1) begin
                fail_cnt++;
                $display("FAIL random_abort%0d: ov=%0d expected -1", i, ov_k);
            end
        end
    endtask

    task automatic test_reset_mid_round;
        int ov_k;
        @(negedge clk);
        start_valid_b = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            assert_cnt++;
            if (obs_b !== model_at(k, 8, 1'b0, 1'b0)) begin
                fail_cnt++;
                $display("FAIL r8_pre_k%0d: got %h expected %h", k, obs_b, model_at(k, 8, 1'b0, 1'b0));
            end
            start_valid_b = 1'b0;
        end
        rst_b = 1'b1;
        @(negedge clk);
        assert_cnt++;
        if (obs_b !== vec(0, 0, 0, 0, 0)) begin
            fail_cnt++;
            $display("FAIL r8_reset: got %h expected %h", obs_b, vec(0, 0, 0, 0, 0));
        end
        rst_b = 1'b0;
        @(negedge clk);
        start_valid_b = 1'b1;
        ov_k = -1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            start_valid_b = 1'b0;
            assert_cnt++;
            if (obs_b !== ((k > 11) ? vec(0, 0, 0, 0, 0) : model_at(k, 8, 1'b0, 1'b0))) begin
                fail_cnt++;
                $display("FAIL r8_run_k%0d: got %h", k, obs_b);
            end
            if (out_valid_b && ov_k < 0) ov_k = k;
        end
        assert_cnt++;
        if (ov_k !== 11) begin
            fail_cnt++;
            $display("FAIL r8_latency: got %0d expected 11", ov_k);
        end
    endtask

    initial begin
        test_reset();
        test_des_encrypt();
        test_3des_decrypt();
        test_key_missing();
        test_backpressure();
        test_abort();
        test_random();
        test_reset_mid_round();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/des_tdes_control_unit.md
DES_TDES_CONTROL_UNIT -- requirements
Module: des_tdes_control_unit

Interface
REQ-001 SHALL have parameter ROUNDS, default 16, rounds per DES pass; legal range 2..31.
REQ-002 SHALL have parameter CNT_W, default 5, width of round_idx; constraint 2^CNT_W > ROUNDS.
REQ-003 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start_valid, input, 1, request to begin an operation.
REQ-006 SHALL have port start_ready, output, 1, block can accept a request.
REQ-007 SHALL have port mode_3des, input, 1, 1 = 3DES EDE (3 passes), 0 = single DES; sampled at accept.
REQ-008 SHALL have port decrypt, input, 1, 1 = decrypt, 0 = encrypt; sampled at accept.
REQ-009 SHALL have port key_ready, input, 1, key material valid; sampled only at accept.
REQ-010 SHALL have port abort, input, 1, cancels an operation in progress.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-012 SHALL have port out_valid, output, 1, result available.
REQ-013 SHALL have port error, output, 1, request rejected.
REQ-014 SHALL have port busy, output, 1, high in LOAD, ROUND or FINAL.
REQ-015 SHALL have port pass_idx, output, 2, current pass, 0..2.
REQ-016 SHALL have port round_idx, output, CNT_W, current round within the pass, 0..ROUNDS-1.
REQ-017 SHALL have port key_sel, output, 2, key slot for the current pass: 0=K1, 1=K2, 2=K3.
REQ-018 SHALL have port key_dir, output, 1, subkey order: 1 = reverse (decrypt) schedule.
REQ-019 SHALL have port en_ip, output, 1, initial permutation enable.
REQ-020 SHALL have port en_round, output, 1, one Feistel round enable.
REQ-021 SHALL have port en_fp, output, 1, final permutation enable.
REQ-022 SHALL have port sel_input, output, 1, datapath selects external input.
REQ-023 SHALL have port state, output, 3, state encoding: IDLE=0, LOAD=1, ROUND=2, FINAL=3, DONE=4, ERROR=5.

Function
REQ-024 SHALL define start_ready=1 only in IDLE; a request is accepted when start_valid && start_ready.
REQ-025 SHALL, on accept, latch mode_3des and decrypt; next state is LOAD if key_ready=1, else ERROR.
REQ-026 SHALL, in LOAD (1 cycle), drive en_ip=1, sel_input=1, pass_idx=0, round_idx=0, then go to ROUND.
REQ-027 SHALL, in ROUND, drive en_round=1 every cycle and increment round_idx by 1 per cycle.
REQ-028 SHALL, at round_idx=ROUNDS-1 with pass_idx<last_pass, wrap round_idx to 0, increment pass_idx and stay in ROUND with no gap cycle; last_pass = 2 if 3DES, else 0.
REQ-029 SHALL, at round_idx=ROUNDS-1 with pass_idx=last_pass, go to FINAL.
REQ-030 SHALL not issue en_fp or en_ip between passes (inner FP/IP pairs cancel and are fused).
REQ-031 SHALL derive key_sel: DES = 0; 3DES encrypt = pass_idx; 3DES decrypt = 2 - pass_idx.
REQ-032 SHALL derive key_dir = decrypt XOR (mode_3des && pass_idx==1), using latched values.
REQ-033 SHALL, in FINAL (1 cycle), drive en_fp=1, then go to DONE.
REQ-034 SHALL, in DONE, hold out_valid=1 until out_ready=1, then go to IDLE on that edge.
REQ-035 SHALL, in ERROR, hold error=1 and return to IDLE on the first cycle with start_valid=0.
REQ-036 SHALL, on abort=1 in LOAD, ROUND or FINAL, go to IDLE next cycle with counters cleared and no out_valid; abort takes priority over round and pass advance.
REQ-037 SHALL ignore abort in IDLE, DONE and ERROR.
REQ-038 SHALL ignore key_ready, mode_3des and decrypt changes after accept.
REQ-039 SHALL give latency from the accept cycle to the first out_valid=1 cycle of 3 + ROUNDS × passes cycles, where passes is 1 or 3.
REQ-040 SHALL drive every enable output to 0 in states where this section does not assert it.

Reset
REQ-041 SHALL, while rst=1, force state=IDLE, pass_idx=0, round_idx=0 and clear the latched mode and decrypt regardless of current state, including mid-operation.
REQ-042 SHALL drive these output values during and after reset: start_ready=1, sel_input=0, and 0 on all other outputs.

Verification
REQ-043 SHALL cover DES encrypt: accept with key_ready=1, out_ready=1 -> en_round high for 16 cycles, key_sel=0, key_dir=0, out_valid on accept+19.
REQ-044 SHALL cover 3DES decrypt: 48 en_round cycles -> key_sel sequence 2,1,0 and key_dir sequence 1,0,1, pass_idx wraps at round_idx=15, out_valid on accept+51.
REQ-045 SHALL cover key missing: accept with key_ready=0 -> state=5, error=1 held; start_valid=0 -> IDLE the next cycle.
REQ-046 SHALL cover backpressure: out_ready=0 for 5 cycles in DONE -> out_valid stays 1 and start_ready stays 0; out_ready=1 -> IDLE.
REQ-047 SHALL cover abort at pass_idx=1, round_idx=7 -> IDLE next cycle, no en_fp and no out_valid; a new request is then accepted normally.
REQ-048 SHALL cover reset mid-ROUND and ROUNDS=8: rst pulse -> all outputs take reset values next cycle; a DES run with ROUNDS=8 gives out_valid on accept+11.
